// File: rtl/full_subtractor_reg.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor_reg
// Description : Registered ripple-borrow subtractor, d = a - b - bin.
//               A per-bit full-subtractor chain feeds one output register
//               stage with a valid flag. At WIDTH=1 it is the classic
//               full-subtractor cell. At wider widths it is a ripple-borrow
//               slice whose borrow-out can be chained to a following stage.
//
// Parameters  : WIDTH      operand / difference width in bits (>= 1)
//
// Ports       : clk        system clock, rising-edge active
//               rst        asynchronous active-high reset
//               valid_in   qualifies a, b, bin this cycle
//               a          minuend (unsigned, WIDTH bits)
//               b          subtrahend (unsigned, WIDTH bits)
//               bin        borrow-in
//               d          registered difference (WIDTH bits)
//               bout       registered borrow-out
//               valid_out  valid_in delayed by one cycle
//
// Revision    : 1.0  initial release
// ============================================================================
module full_subtractor_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             valid_out
);

    // ------------------------------------------------------------------------
    // Combinational ripple-borrow core.
    // w_borrow[i] is the borrow into bit i; w_borrow[WIDTH] is the borrow-out.
    // ------------------------------------------------------------------------
    logic [WIDTH:0]   w_borrow;
    logic [WIDTH-1:0] w_diff;

    assign w_borrow[0] = bin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            // Bit i borrows when it must take from above: either a=0,b=1
            // outright, or a==b and a borrow is already propagating in.
            assign w_diff[i]       = a[i] ^ b[i] ^ w_borrow[i];
            assign w_borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow[i]);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Output register stage.
    // The result registers load only on qualified cycles so that d/bout hold
    // the last accepted result; the valid flag simply follows valid_in.
    // Reset is asynchronous so outputs clear immediately, discarding any
    // result still in the register.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_d    <= w_diff;
                r_bout <= w_borrow[WIDTH];
            end
        end
    end

    assign d         = r_d;
    assign bout      = r_bout;
    assign valid_out = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_full_subtractor_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_subtractor_reg
// Description : Directed self-checking bench for full_subtractor_reg.
//               Two instances share clock and reset: a 1-bit cell and an
//               8-bit slice. Inputs change on the falling edge, outputs are
//               checked 1 ns after the capturing rising edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_full_subtractor_reg;

    logic       clk = 1'b0;
    logic       rst;

    // 1-bit instance
    logic       v1, a1, b1, bin1;
    logic       d1, bout1, vo1;

    // 8-bit instance
    logic       v8, bin8;
    logic [7:0] a8, b8;
    logic [7:0] d8;
    logic       bout8, vo8;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    full_subtractor_reg #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (v1),
        .a         (a1),
        .b         (b1),
        .bin       (bin1),
        .d         (d1),
        .bout      (bout1),
        .valid_out (vo1)
    );

    full_subtractor_reg #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (v8),
        .a         (a8),
        .b         (b8),
        .bin       (bin8),
        .d         (d8),
        .bout      (bout8),
        .valid_out (vo8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] ed, input logic eb, input logic ev);
        check({tag, ".d"},         {24'd0, d8},    {24'd0, ed});
        check({tag, ".bout"},      {31'd0, bout8}, {31'd0, eb});
        check({tag, ".valid_out"}, {31'd0, vo8},   {31'd0, ev});
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bi);
        @(negedge clk);
        v8 = v; a8 = a; b8 = b; bin8 = bi;
    endtask

    task automatic capture;
        @(posedge clk);
        #1;
    endtask

    // Expected {d,bout} for (a,b,bin) index {a,b,bin}
    logic [1:0] tt [8];

    initial begin
        tt[0] = 2'b00; tt[1] = 2'b11; tt[2] = 2'b11; tt[3] = 2'b01;
        tt[4] = 2'b10; tt[5] = 2'b00; tt[6] = 2'b00; tt[7] = 2'b11;

        rst = 1'b1;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
        v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;

        // Reset state
        #1;
        check8("reset0", 8'h00, 1'b0, 1'b0);
        check("reset0.w1", {29'd0, d1, bout1, vo1}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Put a nonzero result in the registers, then reset between edges
        drive8(1'b1, 8'h80, 8'h01, 1'b0);
        capture();
        check8("pre_rst", 8'h7F, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check8("async_rst", 8'h00, 1'b0, 1'b0);
        capture();
        check8("rst_held", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        v8  = 1'b0;

        // WIDTH=1 truth table, back to back
        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            idx = 3'(i);
            @(negedge clk);
            v1 = 1'b1; a1 = idx[2]; b1 = idx[1]; bin1 = idx[0];
            capture();
            check($sformatf("tt%0d.d", i),    {31'd0, d1},    {31'd0, tt[i][1]});
            check($sformatf("tt%0d.bout", i), {31'd0, bout1}, {31'd0, tt[i][0]});
            check($sformatf("tt%0d.vo", i),   {31'd0, vo1},   32'd1);
        end
        @(negedge clk);
        v1 = 1'b0;

        // WIDTH=8 boundaries
        drive8(1'b1, 8'h00, 8'hFF, 1'b1); capture(); check8("wrap",     8'h00, 1'b1, 1'b1);
        drive8(1'b1, 8'h80, 8'h01, 1'b0); capture(); check8("msb",      8'h7F, 1'b0, 1'b1);
        drive8(1'b1, 8'h5A, 8'h5A, 1'b0); capture(); check8("equal",    8'h00, 1'b0, 1'b1);
        drive8(1'b1, 8'hFF, 8'h00, 1'b0); capture(); check8("allones",  8'hFF, 1'b0, 1'b1);
        drive8(1'b1, 8'h00, 8'h00, 1'b1); capture(); check8("binonly",  8'hFF, 1'b1, 1'b1);

        // Hold
        drive8(1'b1, 8'h01, 8'h00, 1'b0); capture(); check8("hold_ld",  8'h01, 1'b0, 1'b1);
        drive8(1'b0, 8'h33, 8'h77, 1'b1); capture(); check8("hold",     8'h01, 1'b0, 1'b0);
        capture();                                   check8("hold2",    8'h01, 1'b0, 1'b0);

        // Back-to-back with reset after the second set
        drive8(1'b1, 8'h0A, 8'h03, 1'b0); capture(); check8("b2b1",     8'h07, 1'b0, 1'b1);
        drive8(1'b1, 8'h03, 8'h0A, 1'b0); capture(); check8("b2b2",     8'hF9, 1'b1, 1'b1);
        drive8(1'b1, 8'h20, 8'h01, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check8("mid_rst",  8'h00, 1'b0, 1'b0);
        capture();
        check8("mid_held", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        v8  = 1'b0;
        capture();
        check8("no_set3",  8'h00, 1'b0, 1'b0);
        drive8(1'b1, 8'h55, 8'h22, 1'b1); capture(); check8("resume",   8'h32, 1'b0, 1'b1);

        // Random WIDTH=8 against arithmetic reference
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra, rb, ed;
            logic       rbi, eb;
            int         diff;
            ra  = 8'($urandom_range(255));
            rb  = 8'($urandom_range(255));
            rbi = 1'($urandom_range(1));
            diff = int'(ra) - int'(rb) - int'(rbi);
            ed  = 8'(diff & 255);
            eb  = (int'(ra) < int'(rb) + int'(rbi));
            drive8(1'b1, ra, rb, rbi);
            capture();
            check8("rand", ed, eb, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
